// File: rtl/serial_add_pkg.sv
// Shared FSM encoding and default sizing for the bit-serial adder sequencer.
package serial_add_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultLat   = 2;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StFin
    } state_e;

endpackage

// File: rtl/serial_add_wait_cnt.sv
// Loadable down-counter with a zero flag; times the full-adder latency window.
module serial_add_wait_cnt #(
    parameter int unsigned CntW = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic [CntW-1:0] i_load_val,
    input  logic            i_dec,
    output logic            o_zero
);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CntW'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: feeds an external 1-bit full adder LSB first and
// collects its Sum/Carry_out after a fixed latency.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned LAT   = DefaultLat
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(WIDTH - 1);
    localparam logic [CntW-1:0] WaitLoad = CntW'(LAT - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [IdxW-1:0]  r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic             r_fa_a;
    logic             r_fa_b;
    logic             r_fa_cin;

    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    logic [IdxW-1:0]  w_idx_nxt;

    assign w_cnt_load = (r_state == StIssue);
    assign w_cnt_dec  = (r_state == StWait);
    assign w_idx_nxt  = r_idx + IdxW'(1);

    serial_add_wait_cnt #(
        .CntW(CntW)
    ) u_wait_cnt (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_load    (w_cnt_load),
        .i_load_val(WaitLoad),
        .i_dec     (w_cnt_dec),
        .o_zero    (w_cnt_zero)
    );

    // Outputs are registered, so fa_* are loaded on the edge that enters ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_fa_a   <= 1'b0;
            r_fa_b   <= 1'b0;
            r_fa_cin <= 1'b0;
        end else begin
            r_fa_a   <= 1'b0;
            r_fa_b   <= 1'b0;
            r_fa_cin <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_carry  <= cin;
                        r_idx    <= '0;
                        r_fa_a   <= a[0];
                        r_fa_b   <= b[0];
                        r_fa_cin <= cin;
                        r_busy   <= 1'b1;
                        r_state  <= StIssue;
                    end
                end
                StIssue: begin
                    r_state <= StWait;
                end
                StWait: begin
                    if (w_cnt_zero) begin
                        r_sum[r_idx] <= fa_sum;
                        r_carry      <= fa_cout;
                        if (r_idx == LastIdx) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_cout  <= fa_cout;
                            r_state <= StFin;
                        end else begin
                            r_idx    <= w_idx_nxt;
                            r_fa_a   <= r_a[w_idx_nxt];
                            r_fa_b   <= r_b[w_idx_nxt];
                            r_fa_cin <= fa_cout;
                            r_state  <= StIssue;
                        end
                    end
                end
                StFin: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign sum    = r_sum;
    assign cout   = r_cout;
    assign fa_a   = r_fa_a;
    assign fa_b   = r_fa_b;
    assign fa_cin = r_fa_cin;

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: two configurations, each driving a latency-modelled
// full adder, checked against plain integer addition and the expected bit schedule.
module tb_serial_add_seq;

    localparam int unsigned W0 = 8;
    localparam int unsigned L0 = 2;
    localparam int unsigned W1 = 4;
    localparam int unsigned L1 = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cur_sel;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_cin;

    logic       start0, busy0, done0, cout0, fa_a0, fa_b0, fa_cin0, fa_sum0, fa_cout0;
    logic [7:0] sum0;
    logic       start1, busy1, done1, cout1, fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1;
    logic [3:0] sum1;

    logic [1:0] pipe0 [L0];
    logic [1:0] pipe1 [L1];

    logic       w_busy, w_done, w_cout;
    logic [7:0] w_sum;
    logic [2:0] w_fa;

    int checks = 0;
    int errors = 0;

    int         obs_done_at, obs_done_cnt, obs_fa_bad, obs_busy_bad, obs_rst_bad;
    logic [7:0] obs_sum;
    logic       obs_cout;

    always #5 clk = ~clk;

    assign start0 = start & ~cur_sel;
    assign start1 = start & cur_sel;
    assign w_busy = cur_sel ? busy1 : busy0;
    assign w_done = cur_sel ? done1 : done0;
    assign w_cout = cur_sel ? cout1 : cout0;
    assign w_sum  = cur_sel ? {4'b0, sum1} : sum0;
    assign w_fa   = cur_sel ? {fa_a1, fa_b1, fa_cin1} : {fa_a0, fa_b0, fa_cin0};

    serial_add_seq #(.WIDTH(W0), .LAT(L0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(op_a), .b(op_b), .cin(op_cin),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0),
        .fa_a(fa_a0), .fa_b(fa_b0), .fa_cin(fa_cin0), .fa_sum(fa_sum0), .fa_cout(fa_cout0)
    );

    serial_add_seq #(.WIDTH(W1), .LAT(L1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(op_a[3:0]), .b(op_b[3:0]), .cin(op_cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_sum(fa_sum1), .fa_cout(fa_cout1)
    );

    // Full-adder models: {carry, sum} of the inputs, delayed by LAT clocks.
    always @(posedge clk) begin
        pipe0[0] <= 2'(fa_a0) + 2'(fa_b0) + 2'(fa_cin0);
        for (int i = 1; i < int'(L0); i++) pipe0[i] <= pipe0[i-1];
        pipe1[0] <= 2'(fa_a1) + 2'(fa_b1) + 2'(fa_cin1);
        for (int i = 1; i < int'(L1); i++) pipe1[i] <= pipe1[i-1];
    end
    assign fa_sum0  = pipe0[L0-1][0];
    assign fa_cout0 = pipe0[L0-1][1];
    assign fa_sum1  = pipe1[L1-1][0];
    assign fa_cout1 = pipe1[L1-1][1];

    // Runs one addition and records what the DUT did; comparisons live in the callers.
    task automatic run_op(input logic sel, input logic [7:0] ta, input logic [7:0] tbv,
                          input logic tcin, input int pulse_at, input int rst_at);
        int          w, l, n, i;
        int unsigned mask, carry;
        bit          aborted;
        logic [2:0]  exp_fa;
        w = sel ? int'(W1) : int'(W0);
        l = sel ? int'(L1) : int'(L0);
        n = w * (l + 1);
        obs_done_at = -1; obs_done_cnt = 0; obs_fa_bad = 0; obs_busy_bad = 0; obs_rst_bad = 0;
        obs_sum = '0; obs_cout = 1'b0;
        @(negedge clk);
        cur_sel = sel; op_a = ta; op_b = tbv; op_cin = tcin; start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k <= n + 3; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            start = 1'b0;
            if (rst_at >= 0 && k == rst_at + 1) rst = 1'b0;
            aborted = (rst_at >= 0) && (k > rst_at);
            exp_fa = 3'b000;
            if (!aborted && (k % (l + 1)) == 0 && (k / (l + 1)) < w) begin
                i = k / (l + 1);
                mask = (32'd1 << i) - 32'd1;
                carry = ((int'(ta) & mask) + (int'(tbv) & mask) + int'(tcin)) >> i;
                exp_fa = {ta[i], tbv[i], carry[0]};
            end
            if (w_fa !== exp_fa) obs_fa_bad++;
            if (w_busy !== (!aborted && k < n)) obs_busy_bad++;
            if (aborted && k == rst_at + 1 && (w_sum !== 8'h00 || w_cout !== 1'b0))
                obs_rst_bad++;
            if (w_done === 1'b1) begin
                obs_done_cnt++;
                if (obs_done_at < 0) obs_done_at = k;
                obs_sum = w_sum;
                obs_cout = w_cout;
            end
            if (k == pulse_at) start = 1'b1;
            if (k == rst_at) rst = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cur_sel = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b want 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done0: got %b want 0", done0); end
        checks++; if (sum0 !== 8'h00) begin errors++; $display("FAIL reset_sum0: got %h want 00", sum0); end
        checks++; if (cout0 !== 1'b0) begin errors++; $display("FAIL reset_cout0: got %b want 0", cout0); end
        checks++; if ({fa_a0, fa_b0, fa_cin0} !== 3'b000) begin errors++; $display("FAIL reset_fa0: got %b want 000", {fa_a0, fa_b0, fa_cin0}); end
        checks++; if ({busy1, done1, cout1, sum1} !== 7'h00) begin errors++; $display("FAIL reset_dut1: got %h want 00", {busy1, done1, cout1, sum1}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] va [3] = '{8'h0F, 8'hFF, 8'h00};
        logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h00};
        logic       vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] vs [3] = '{8'h10, 8'h00, 8'h01};
        logic       vo [3] = '{1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            run_op(1'b0, va[t], vb[t], vc[t], -1, -1);
            checks++; if (obs_sum !== vs[t]) begin errors++; $display("FAIL directed%0d_sum: got %h want %h", t, obs_sum, vs[t]); end
            checks++; if (obs_cout !== vo[t]) begin errors++; $display("FAIL directed%0d_cout: got %b want %b", t, obs_cout, vo[t]); end
            checks++; if (obs_done_at != 24) begin errors++; $display("FAIL directed%0d_done_cycle: got S+%0d want S+25", t, obs_done_at + 1); end
            checks++; if (obs_done_cnt != 1) begin errors++; $display("FAIL directed%0d_done_count: got %0d want 1", t, obs_done_cnt); end
            checks++; if (obs_fa_bad != 0) begin errors++; $display("FAIL directed%0d_fa_drive: got %0d bad cycles want 0", t, obs_fa_bad); end
            checks++; if (obs_busy_bad != 0) begin errors++; $display("FAIL directed%0d_busy: got %0d bad cycles want 0", t, obs_busy_bad); end
        end
    endtask

    task automatic test_start_ignored();
        run_op(1'b0, 8'h12, 8'h34, 1'b0, 4, -1);
        checks++; if (obs_done_cnt != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", obs_done_cnt); end
        checks++; if (obs_sum !== 8'h46) begin errors++; $display("FAIL ignore_sum: got %h want 46", obs_sum); end
        checks++; if (obs_done_at != 24) begin errors++; $display("FAIL ignore_done_cycle: got %0d want 24", obs_done_at); end
        checks++; if (obs_busy_bad != 0) begin errors++; $display("FAIL ignore_busy: got %0d bad cycles want 0", obs_busy_bad); end
    endtask

    task automatic test_reset_mid();
        run_op(1'b0, 8'h3C, 8'h42, 1'b1, -1, 9);
        checks++; if (obs_rst_bad != 0) begin errors++; $display("FAIL midrst_clear: got %0d bad want 0", obs_rst_bad); end
        checks++; if (obs_done_cnt != 0) begin errors++; $display("FAIL midrst_no_done: got %0d done pulses want 0", obs_done_cnt); end
        checks++; if (obs_busy_bad != 0) begin errors++; $display("FAIL midrst_busy: got %0d bad cycles want 0", obs_busy_bad); end
        checks++; if (obs_fa_bad != 0) begin errors++; $display("FAIL midrst_fa: got %0d bad cycles want 0", obs_fa_bad); end
        run_op(1'b0, 8'hA5, 8'h5A, 1'b0, -1, -1);
        checks++; if (obs_sum !== 8'hFF || obs_cout !== 1'b0) begin errors++; $display("FAIL midrst_restart: got %h/%b want ff/0", obs_sum, obs_cout); end
    endtask

    task automatic test_lat3();
        run_op(1'b1, 8'h09, 8'h07, 1'b0, -1, -1);
        checks++; if (obs_sum !== 8'h00 || obs_cout !== 1'b1) begin errors++; $display("FAIL lat3_result: got %h/%b want 0/1", obs_sum, obs_cout); end
        checks++; if (obs_done_at != 16) begin errors++; $display("FAIL lat3_done_cycle: got S+%0d want S+17", obs_done_at + 1); end
        checks++; if (obs_fa_bad != 0 || obs_busy_bad != 0) begin errors++; $display("FAIL lat3_timing: got fa %0d busy %0d bad want 0", obs_fa_bad, obs_busy_bad); end
    endtask

    task automatic test_random();
        logic [7:0]  ra, rb;
        logic        rc, sel;
        int          w, l;
        int unsigned full;
        for (int t = 0; t < 16; t++) begin
            sel = (t >= 11);
            w = sel ? int'(W1) : int'(W0);
            l = sel ? int'(L1) : int'(L0);
            ra = sel ? 8'($urandom_range(0, 15)) : 8'($urandom);
            rb = sel ? 8'($urandom_range(0, 15)) : 8'($urandom);
            rc = 1'($urandom);
            full = int'(ra) + int'(rb) + int'(rc);
            run_op(sel, ra, rb, rc, -1, -1);
            checks++;
            if (obs_sum !== 8'(full % (32'd1 << w)) || obs_cout !== full[w]
                || obs_done_at != w * (l + 1) || obs_fa_bad != 0 || obs_busy_bad != 0) begin
                errors++;
                $display("FAIL random%0d %h+%h+%b: got sum %h cout %b done %0d fa %0d busy %0d want sum %h cout %b done %0d",
                         t, ra, rb, rc, obs_sum, obs_cout, obs_done_at, obs_fa_bad, obs_busy_bad,
                         8'(full % (32'd1 << w)), full[w], w * (l + 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a1, b1, a2, b2;
        int unsigned f1, f2;
        a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
        f1 = int'(a1) + int'(b1);
        f2 = int'(a2) + int'(b2) + 1;
        @(negedge clk);
        cur_sel = 1'b0; op_a = a1; op_b = b1; op_cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done0 === 1'b1) break;
        end
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", done0); end
        checks++; if (sum0 !== f1[7:0]) begin errors++; $display("FAIL b2b_first_sum: got %h want %h", sum0, f1[7:0]); end
        op_a = a2; op_b = b2; op_cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_not_in_fin: got busy %b want 0", busy0); end
        checks++; if (sum0 !== f1[7:0] || cout0 !== f1[8]) begin errors++; $display("FAIL b2b_hold: got %h/%b want %h/%b", sum0, cout0, f1[7:0], f1[8]); end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b want 1", busy0); end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done0 === 1'b1) break;
        end
        checks++; if (done0 !== 1'b1 || sum0 !== f2[7:0] || cout0 !== f2[8]) begin errors++; $display("FAIL b2b_second: got done %b %h/%b want 1 %h/%b", done0, sum0, cout0, f2[7:0], f2[8]); end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_mid();
        test_lat3();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (2..64).
REQ-002 SHALL have parameter LAT, default 2, clock cycles from a bit-adder input to its Sum/Carry_out (1..4).
REQ-003 SHALL be a single-clock design: clk is the one clock, and reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  request to add a, b and cin; sampled only in IDLE.
REQ-007 SHALL have port a  input  WIDTH  operand A; captured on start acceptance.
REQ-008 SHALL have port b  input  WIDTH  operand B; captured on start acceptance.
REQ-009 SHALL have port cin  input  1  initial carry; captured on start acceptance.
REQ-010 SHALL have port busy  output  1  high while an addition is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when sum and cout are valid.
REQ-012 SHALL have port sum  output  WIDTH  result (a+b+cin) mod 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-014 SHALL have port fa_a, fa_b, fa_cin  output  1 each  bit drive to the downstream 1-bit full adder (A, B, Carry_in).
REQ-015 SHALL have port fa_sum, fa_cout  input  1 each  Sum and Carry_out returned by the full adder.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, FIN.
REQ-017 SHALL in IDLE with start=1 latch a, b and cin, clear the bit index, and go to ISSUE on the next cycle.
REQ-018 SHALL in ISSUE (one cycle) drive fa_a=a_reg[idx], fa_b=b_reg[idx] and fa_cin=carry_reg, then go to WAIT.
REQ-019 SHALL drive fa_a, fa_b and fa_cin to 0 in every non-ISSUE cycle (no pulse).
REQ-020 SHALL in WAIT count LAT-1 cycles, then on the cycle exactly LAT after ISSUE capture fa_sum into sum[idx] and fa_cout into carry_reg.
REQ-021 SHALL after each capture either increment idx and return to ISSUE when idx<WIDTH-1, or go to FIN.
REQ-022 SHALL give a per-bit period of LAT+1 cycles, so issue cycles are spaced LAT+1 apart with LSB first.
REQ-023 SHALL in FIN assert done for exactly one cycle, present cout=carry_reg, and return to IDLE.
REQ-024 SHALL assert done in cycle S+WIDTH*(LAT+1)+1, where S is the start-acceptance edge (WIDTH=8, LAT=2: cycle S+25).
REQ-025 SHALL hold busy=1 from the cycle after acceptance through the last capture cycle, and busy=0 in IDLE and FIN.
REQ-026 SHALL ignore start while busy or in FIN, with no queueing.
REQ-027 SHALL hold sum and cout stable from done until the next accepted start; sum bits update only at their capture cycles.
REQ-028 SHALL sample fa_sum and fa_cout only at capture cycles; values at other cycles have no effect.
REQ-029 SHALL accept a start asserted in the same cycle done is high only after the return to IDLE, i.e. the next cycle.

Reset
REQ-030 SHALL on rst=1 at a clock edge go to IDLE and clear busy, done, sum, cout, fa_a, fa_b, fa_cin, idx, carry_reg and the wait counter to 0.
REQ-031 SHALL on rst mid-operation abandon the addition, produce no done pulse, and ignore any later fa_sum/fa_cout pulses from the abandoned bit.
REQ-032 SHALL give rst priority over start.

Structure
REQ-033 SHALL place the FSM state enumeration and the default constants WIDTH=8 and LAT=2 in a shared package serial_add_pkg.
REQ-034 SHALL use one sub-module, serial_add_wait_cnt: a loadable down-counter with a zero flag that times the LAT wait.
REQ-035 SHALL instantiate no full adder; the 1-bit adder is external and connected through the fa_* ports.

Verification
REQ-036 SHALL be verified with a bench modelling the full adder with LAT-cycle latency and covering these directed scenarios:
- a=8'h0F, b=8'h01, cin=0 -> sum=8'h10, cout=0, done at S+25.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
- a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0; fa_* are 0 in all non-ISSUE cycles.
- start pulsed at S+5 during busy -> ignored, exactly one done, result unchanged.
- rst at S+10 -> busy=0, sum=0, no done; a new start a=8'hA5, b=8'h5A -> sum=8'hFF, cout=0.
- LAT=3, WIDTH=4, a=4'h9, b=4'h7 -> sum=4'h0, cout=1, done at S+17.
